rx_frame_sync: RTL and testbench
================================

# rx_frame_sync

Receive-side frame synchroniser that sits directly downstream of the preamble detector. After `PD_flag` rises it hunts for the sync word in the demodulated BPSK bit stream and resolves the 180° phase ambiguity from the sync polarity. It then deframes a length-prefixed payload into bytes, checks a modulo-256 checksum, and pulses `disassert_PD` to re-arm preamble detection for the next packet.

## Interface
- `SYNC_WORD`, 16'hF3A5: sync pattern, MSB received first.
- `TIMEOUT_BITS`, 256: maximum number of valid bits searched after `PD_flag` before giving up.
- `CNT_WIDTH`, 9: width of the search bit counter; must hold `TIMEOUT_BITS`.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `BPSK` in 1: hard-decided demodulated bit.
- `bit_valid` in 1: `BPSK` is sampled only in cycles where this is high.
- `SD_flag` in 1: signal-detect; low aborts any frame in progress.
- `PD_flag` in 1: preamble-detected flag from the preamble detector.
- `disassert_PD` out 1: one-cycle pulse that clears `PD_flag` upstream.
- `frame_start` out 1: one-cycle pulse on sync-word match.
- `sync_inv` out 1: 1 if the sync word matched inverted; held until the next `frame_start`.
- `payload_len` out 8: received length byte, valid from the cycle after the length is captured until the next `frame_start`.
- `data_out` out 8: payload byte, polarity-corrected.
- `data_valid` out 1: one-cycle strobe qualifying `data_out`.
- `frame_end` out 1: one-cycle pulse at end or abort of a frame.
- `frame_err` out 1: high only together with `frame_end`; indicates checksum mismatch or abort.

## Operation
- **Frame format on air:** preamble, then `SYNC_WORD` (16 b), then length L (8 b), then L payload bytes, then checksum C (8 b). All fields are MSB first.
- **Checksum:** C = (L + Σ payload bytes) mod 256, computed after polarity correction.
- **Polarity correction:** corrected bit = `BPSK ^ sync_inv`.
- **FSM states:** IDLE, SEARCH, LEN, PAYLOAD, CHECK, DONE.
- **IDLE:**
  - Go to SEARCH on a rising edge of `PD_flag` (`PD_flag` high and its registered copy low) while `SD_flag` is high.
  - On entry to SEARCH, clear the 16-bit shift register and the bit counter.
- **SEARCH:**
  - Each valid bit shifts into the shift register and increments the counter.
  - Once at least 16 bits have been received, compare the next shift-register value (including the current bit):
    - equal to `SYNC_WORD`: `sync_inv`=0, pulse `frame_start`, go to LEN;
    - equal to `~SYNC_WORD`: `sync_inv`=1, pulse `frame_start`, go to LEN;
    - otherwise stay in SEARCH.
  - If the counter reaches `TIMEOUT_BITS` with no match, pulse `disassert_PD` and go to IDLE. No `frame_end` on timeout.
- **LEN:**
  - Collect 8 corrected bits into `payload_len` and seed the checksum accumulator with L.
  - L=0: go directly to CHECK.
  - Otherwise go to PAYLOAD with the byte counter = L.
- **PAYLOAD:**
  - Every 8 corrected bits: present the byte on `data_out`, pulse `data_valid`, add the byte to the accumulator, decrement the byte counter.
  - After the last byte, go to CHECK.
- **CHECK:** collect 8 bits, compare them with the accumulator, go to DONE.
- **DONE:** lasts exactly one cycle.
  - Pulse `frame_end`, with `frame_err` = mismatch.
  - Pulse `disassert_PD`.
  - Go to IDLE.
- **Abort:** `SD_flag` low in LEN, PAYLOAD or CHECK. The next cycle pulses `frame_end`=1 and `frame_err`=1, with no `disassert_PD` (upstream already clears on SD loss), and the FSM returns to IDLE. `SD_flag` low in SEARCH returns to IDLE silently.
- **Accumulator:** 8 bits, wrapping; carries are discarded.

## Timing
- **Reset values:** all outputs 0; FSM in IDLE; shift register, counters and accumulator 0. Reset takes effect immediately, mid-frame included, with no trailing pulses after release.
- **Output registration:** all outputs are registered.
- **Sync detect:** the bit that completes the sync word is sampled at edge k; `frame_start` is high in the cycle following edge k. The first LEN bit is the next valid bit after edge k.
- **Payload bytes:** when the 8th bit of a byte is sampled at edge k, `data_out`/`data_valid` are valid in the cycle following edge k.
- **End of frame:** the last checksum bit is sampled at edge k. The FSM is in DONE in the cycle after edge k, and `frame_end`, `frame_err` and `disassert_PD` are high in that same cycle.
- **Re-arm:** IDLE is re-entered one cycle later. Because IDLE waits for a fresh `PD_flag` rising edge, a stale `PD_flag` cannot retrigger.
- **bit_valid low:** when low, no state advances except abort, timeout bookkeeping and the DONE→IDLE step.
- **Throughput:** back-to-back valid bits every cycle are supported.
- **Same-cycle SD loss and last bit:** if `SD_flag` falls in the same cycle as the last checksum bit, abort wins.

## Test plan
- **Clean frame:** preamble, 16'hF3A5, L=3, bytes 0x11 0x22 0x33, C=0x69 → three `data_valid` pulses with 0x11/0x22/0x33, `payload_len`=3, `sync_inv`=0, `frame_end`=1 with `frame_err`=0, one `disassert_PD` pulse.
- **Inverted frame:** the same frame with every bit inverted → `sync_inv`=1 and identical bytes and result.
- **Bad checksum:** the clean frame with C=0x6A → `frame_end`=1, `frame_err`=1, `disassert_PD` pulsed.
- **Timeout and empty payload:**
  - `PD_flag` rises, then 256 random bits containing no sync → `disassert_PD` pulse on bit 256, no `frame_start`.
  - L=0 with C=0x00 → no `data_valid`, `frame_err`=0.
- **SD loss mid-payload:** `SD_flag` drops during the 2nd payload byte → `frame_end`/`frame_err` pulse the next cycle, no `disassert_PD`, FSM in IDLE.
- **Reset mid-frame:** `rst_n` asserted mid-frame → all outputs 0 at once. A following clean frame decodes correctly.
- **Gapped input:** `bit_valid` toggling 1-0 throughout the clean frame → same results as the clean frame.

Source files
------------

// File: rtl/rx_frame_sync_if.sv
// rx_frame_sync_if: bit-stream inputs and deframed outputs of the receive frame synchroniser
interface rx_frame_sync_if;
  logic       BPSK;
  logic       bit_valid;
  logic       SD_flag;
  logic       PD_flag;
  logic       disassert_PD;
  logic       frame_start;
  logic       sync_inv;
  logic [7:0] payload_len;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_end;
  logic       frame_err;
  modport master (
    output BPSK, bit_valid, SD_flag, PD_flag,
    input  disassert_PD, frame_start, sync_inv, payload_len, data_out, data_valid, frame_end, frame_err
  );
  modport slave (
    input  BPSK, bit_valid, SD_flag, PD_flag,
    output disassert_PD, frame_start, sync_inv, payload_len, data_out, data_valid, frame_end, frame_err
  );
endinterface

// File: rtl/rx_frame_sync.sv
// rx_frame_sync: sync-word hunt, BPSK polarity resolution, length-prefixed deframing and checksum check
module rx_frame_sync #(
  parameter logic [15:0] SYNC_WORD    = 16'hF3A5,
  parameter int          TIMEOUT_BITS = 256,
  parameter int          CNT_WIDTH    = 9
) (
  input logic            clk,
  input logic            rst_n,
  rx_frame_sync_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEARCH, LEN, PAYLOAD, CHECK, DONE} state_t;
  state_t               state;
  logic                 pd_q;
  logic [15:0]          sr;
  logic [15:0]          sr_nx;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nx;
  logic [2:0]           bit_cnt;
  logic [7:0]           byte_sr;
  logic [7:0]           byte_nx;
  logic [7:0]           bytes_left;
  logic [7:0]           acc;
  logic                 byte_done;
  logic                 in_frame;
  logic                 abort;
  // next-value helpers: raw search window, polarity-corrected byte, end-of-byte and abort detection
  always_comb begin
    sr_nx     = {sr[14:0], bus.BPSK};
    cnt_nx    = cnt + CNT_WIDTH'(1);
    byte_nx   = {byte_sr[6:0], bus.BPSK ^ bus.sync_inv};
    byte_done = bus.bit_valid && bit_cnt == 3'd7;
    in_frame  = state == LEN || state == PAYLOAD || state == CHECK;
    abort     = !bus.SD_flag && in_frame;
  end
  // frame FSM with registered pulses; pulses default low every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      pd_q             <= 1'b0;
      sr               <= '0;
      cnt              <= '0;
      bit_cnt          <= '0;
      byte_sr          <= '0;
      bytes_left       <= '0;
      acc              <= '0;
      bus.disassert_PD <= 1'b0;
      bus.frame_start  <= 1'b0;
      bus.sync_inv     <= 1'b0;
      bus.payload_len  <= '0;
      bus.data_out     <= '0;
      bus.data_valid   <= 1'b0;
      bus.frame_end    <= 1'b0;
      bus.frame_err    <= 1'b0;
    end else begin
      pd_q             <= bus.PD_flag;
      bus.disassert_PD <= 1'b0;
      bus.frame_start  <= 1'b0;
      bus.data_valid   <= 1'b0;
      bus.frame_end    <= 1'b0;
      bus.frame_err    <= 1'b0;
      if (in_frame && bus.bit_valid) begin
        byte_sr <= byte_nx;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (abort) begin
        bus.frame_end <= 1'b1;
        bus.frame_err <= 1'b1;
        state         <= IDLE;
      end else begin
        case (state)
          IDLE: if (bus.PD_flag && !pd_q && bus.SD_flag) begin
            sr    <= '0;
            cnt   <= '0;
            state <= SEARCH;
          end
          SEARCH: if (!bus.SD_flag) state <= IDLE;
          else if (bus.bit_valid) begin
            sr  <= sr_nx;
            cnt <= cnt_nx;
            if (cnt_nx >= CNT_WIDTH'(16) && (sr_nx == SYNC_WORD || sr_nx == ~SYNC_WORD)) begin
              bus.frame_start <= 1'b1;
              bus.sync_inv    <= sr_nx != SYNC_WORD;
              bit_cnt         <= '0;
              state           <= LEN;
            end else if (cnt_nx == CNT_WIDTH'(TIMEOUT_BITS)) begin
              bus.disassert_PD <= 1'b1;
              state            <= IDLE;
            end
          end
          LEN: if (byte_done) begin
            bus.payload_len <= byte_nx;
            acc             <= byte_nx;
            bytes_left      <= byte_nx;
            state           <= byte_nx == 8'd0 ? CHECK : PAYLOAD;
          end
          PAYLOAD: if (byte_done) begin
            bus.data_out   <= byte_nx;
            bus.data_valid <= 1'b1;
            acc            <= acc + byte_nx;
            bytes_left     <= bytes_left - 8'd1;
            if (bytes_left == 8'd1) state <= CHECK;
          end
          CHECK: if (byte_done) begin
            bus.frame_end    <= 1'b1;
            bus.frame_err    <= byte_nx != acc;
            bus.disassert_PD <= 1'b1;
            state            <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_frame_sync.sv
// tb_rx_frame_sync: directed and randomized frames checked against a byte-level frame model
module tb_rx_frame_sync;
  typedef logic [7:0] bq_t[$];
  typedef bit bits_t[$];
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  rx_frame_sync_if bus();
  rx_frame_sync dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_fs, n_fe, n_err, n_dis, fs_cyc, fe_cyc, dis_cyc, sync_cyc, last_cyc;
  logic [7:0] got[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.frame_start) begin n_fs++; fs_cyc = cyc; end
    if (bus.frame_end) begin n_fe++; fe_cyc = cyc; end
    if (bus.frame_err) n_err++;
    if (bus.disassert_PD) begin n_dis++; dis_cyc = cyc; end
    if (bus.data_valid) got.push_back(bus.data_out);
  end
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    n_fs = 0; n_fe = 0; n_err = 0; n_dis = 0;
    fs_cyc = -1; fe_cyc = -1; dis_cyc = -1;
    got.delete();
  endtask
  task automatic step(bit b, bit v);
    bus.BPSK = b;
    bus.bit_valid = v;
    @(posedge clk);
    #1;
  endtask
  task automatic outs_zero(string tag);
    chk(tag, 32'({bus.disassert_PD, bus.frame_start, bus.sync_inv, bus.payload_len, bus.data_out,
                  bus.data_valid, bus.frame_end, bus.frame_err}), 32'd0);
  endtask
  function automatic void push_byte(ref bits_t b, input logic [7:0] v, input bit inv);
    for (int i = 7; i >= 0; i--) b.push_back(v[i] ^ inv);
  endfunction
  // air bits: 0xAAAA preamble, sync, L, payload, checksum (optionally off by one), all optionally inverted
  function automatic bits_t frame_bits(bq_t pl, bit inv, bit badc);
    bits_t b;
    int sum = pl.size();
    push_byte(b, 8'hAA, inv);
    push_byte(b, 8'hAA, inv);
    push_byte(b, 8'hF3, inv);
    push_byte(b, 8'hA5, inv);
    push_byte(b, 8'(pl.size()), inv);
    foreach (pl[i]) begin
      push_byte(b, pl[i], inv);
      sum += pl[i];
    end
    push_byte(b, 8'((sum + (badc ? 1 : 0)) % 256), inv);
    return b;
  endfunction
  task automatic send(bits_t bs, bit gap);
    foreach (bs[i]) begin
      step(bs[i], 1'b1);
      if (i == 31) sync_cyc = cyc;
      last_cyc = cyc;
      if (gap) step(1'b0, 1'b0);
    end
  endtask
  task automatic start();
    clr();
    bus.PD_flag = 1'b1;
    bus.SD_flag = 1'b1;
    step(1'b0, 1'b0);
  endtask
  task automatic release_pd();
    repeat (4) step(1'b0, 1'b0);
    bus.PD_flag = 1'b0;
    step(1'b0, 1'b0);
  endtask
  task automatic frame_check(string tag, bq_t pl, bit inv, bit badc, bit gap);
    start();
    send(frame_bits(pl, inv, badc), gap);
    release_pd();
    chk({tag, ".fs_n"}, 32'(n_fs), 32'd1);
    chk({tag, ".fs_cyc"}, 32'(fs_cyc), 32'(sync_cyc));
    chk({tag, ".n_bytes"}, 32'(got.size()), 32'(pl.size()));
    foreach (pl[i]) if (i < got.size()) chk({tag, ".byte"}, 32'(got[i]), 32'(pl[i]));
    chk({tag, ".len"}, 32'(bus.payload_len), 32'(pl.size()));
    chk({tag, ".inv"}, 32'(bus.sync_inv), 32'(inv));
    chk({tag, ".fe_n"}, 32'(n_fe), 32'd1);
    chk({tag, ".fe_cyc"}, 32'(fe_cyc), 32'(last_cyc));
    chk({tag, ".err_n"}, 32'(n_err), 32'(badc));
    chk({tag, ".dis_n"}, 32'(n_dis), 32'd1);
    chk({tag, ".dis_cyc"}, 32'(dis_cyc), 32'(last_cyc));
  endtask
  initial begin
    bq_t clean, ipl, rpl;
    bits_t bs;
    int w;
    int abort_cyc;
    bit b;
    clean = '{8'h11, 8'h22, 8'h33};
    bus.BPSK = 1'b0; bus.bit_valid = 1'b0; bus.SD_flag = 1'b0; bus.PD_flag = 1'b0;
    clr();
    repeat (3) step(1'b0, 1'b0);
    outs_zero("reset");
    #2 rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0);
    frame_check("clean", clean, 1'b0, 1'b0, 1'b0);
    frame_check("inverted", clean, 1'b1, 1'b0, 1'b0);
    frame_check("badsum", clean, 1'b0, 1'b1, 1'b0);
    frame_check("empty", '{}, 1'b0, 1'b0, 1'b0);
    frame_check("gapped", clean, 1'b0, 1'b0, 1'b1);
    // timeout: 256 bits whose every 16-bit window avoids both sync polarities
    start();
    bs.delete();
    w = 0;
    for (int i = 0; i < 256; i++) begin
      b = 1'($urandom);
      if (i >= 15 && ((((w << 1) | b) & 16'hFFFF) == 16'hF3A5 || (((w << 1) | b) & 16'hFFFF) == 16'h0C5A)) b = ~b;
      w = ((w << 1) | b) & 16'hFFFF;
      bs.push_back(b);
    end
    send(bs, 1'b0);
    release_pd();
    chk("timeout.dis_n", 32'(n_dis), 32'd1);
    chk("timeout.dis_cyc", 32'(dis_cyc), 32'(last_cyc));
    chk("timeout.fs_n", 32'(n_fs), 32'd0);
    chk("timeout.fe_n", 32'(n_fe), 32'd0);
    // SD lost on the 5th bit of the 2nd payload byte
    start();
    bs = frame_bits(clean, 1'b0, 1'b0);
    send(bs[0:51], 1'b0);
    bus.SD_flag = 1'b0;
    step(bs[52], 1'b1);
    abort_cyc = cyc;
    repeat (3) step(1'b0, 1'b0);
    bus.PD_flag = 1'b0;
    bus.SD_flag = 1'b1;
    repeat (2) step(1'b0, 1'b0);
    chk("sdloss.fe_n", 32'(n_fe), 32'd1);
    chk("sdloss.err_n", 32'(n_err), 32'd1);
    chk("sdloss.fe_cyc", 32'(fe_cyc), 32'(abort_cyc));
    chk("sdloss.dis_n", 32'(n_dis), 32'd0);
    chk("sdloss.n_bytes", 32'(got.size()), 32'd1);
    frame_check("after_sdloss", clean, 1'b0, 1'b0, 1'b0);
    // stale PD_flag held high after a frame must not start a second search
    start();
    bs = frame_bits(clean, 1'b0, 1'b0);
    send(bs, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    send(bs, 1'b0);
    release_pd();
    chk("stale.fs_n", 32'(n_fs), 32'd1);
    chk("stale.dis_n", 32'(n_dis), 32'd1);
    // asynchronous reset in the middle of an inverted frame
    ipl = '{8'hA5, 8'h5A, 8'hFF};
    start();
    bs = frame_bits(ipl, 1'b1, 1'b0);
    send(bs[0:60], 1'b0);
    chk("midrst.pre_inv", 32'(bus.sync_inv), 32'd1);
    chk("midrst.pre_len", 32'(bus.payload_len), 32'd3);
    #2 rst_n = 1'b0;
    #1 outs_zero("midrst.now");
    clr();
    bus.PD_flag = 1'b0;
    repeat (2) step(1'b0, 1'b0);
    #2 rst_n = 1'b1;
    repeat (5) step(1'b1, 1'b1);
    chk("midrst.quiet", 32'(n_fs + n_fe + n_dis + got.size()), 32'd0);
    outs_zero("midrst.after");
    frame_check("after_rst", clean, 1'b0, 1'b0, 1'b0);
    // randomized frames
    for (int t = 0; t < 8; t++) begin
      rpl.delete();
      repeat ($urandom_range(0, 6)) rpl.push_back(8'($urandom));
      frame_check($sformatf("rand%0d", t), rpl, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
